// File: rtl/execute_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module : execute_stage_pipe
// Desc   : Execute stage with single-cycle ALU, iterative MUL/DIVU and CP0.
// Rev    : 1.0  initial release
// ============================================================================
module execute_stage_pipe #(
  parameter int          DATA_W     = 32,
  parameter logic [31:0] EXC_VECTOR = 32'h0040_00EC,
  parameter int          MD_ITER    = DATA_W,
  localparam int         SHAMT_W    = (DATA_W == 64) ? 6 : 5
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [3:0]          op_sel_i,
  input  logic [DATA_W-1:0]   src_a_i,
  input  logic [DATA_W-1:0]   src_b_i,
  input  logic [DATA_W-1:0]   pc_4_i,
  input  logic [DATA_W-1:0]   imm_ext_i,
  input  logic [SHAMT_W-1:0]  shamt_i,
  input  logic [25:0]         instr_index_i,
  input  logic                branch_i,
  input  logic                jr_i,
  input  logic                j_i,
  input  logic                link_i,
  input  logic [1:0]          cp0_sel_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [DATA_W-1:0]   out_result_o,
  output logic [DATA_W-1:0]   out_pc_next_o,
  output logic                out_redirect_o,
  output logic                busy_o,
  output logic                exl_o
);

  localparam logic [3:0] c_OP_ADD     = 4'd0;
  localparam logic [3:0] c_OP_SUB     = 4'd1;
  localparam logic [3:0] c_OP_AND     = 4'd2;
  localparam logic [3:0] c_OP_OR      = 4'd3;
  localparam logic [3:0] c_OP_XOR     = 4'd4;
  localparam logic [3:0] c_OP_SLT     = 4'd5;
  localparam logic [3:0] c_OP_SLL     = 4'd6;
  localparam logic [3:0] c_OP_SRL     = 4'd7;
  localparam logic [3:0] c_OP_MUL     = 4'd8;
  localparam logic [3:0] c_OP_DIVU    = 4'd9;
  localparam logic [3:0] c_OP_SYSCALL = 4'd10;
  localparam logic [3:0] c_OP_ERET    = 4'd11;
  localparam logic [3:0] c_OP_MFC0    = 4'd12;
  localparam logic [3:0] c_OP_MTC0    = 4'd13;

  localparam int                c_CNT_W   = $clog2(MD_ITER + 1);
  localparam logic [DATA_W-1:0] c_EXC_VEC = DATA_W'(EXC_VECTOR);
  localparam logic [4:0]        c_EXC_SYS = 5'd8;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  state_e              state_q,        state_d;
  logic                out_valid_q,    out_valid_d;
  logic [DATA_W-1:0]   out_result_q,   out_result_d;
  logic [DATA_W-1:0]   out_pc_next_q,  out_pc_next_d;
  logic                out_redirect_q, out_redirect_d;
  logic [DATA_W-1:0]   epc_q,          epc_d;
  logic [DATA_W-1:0]   cause_q,        cause_d;
  logic [DATA_W-1:0]   status_q,       status_d;
  logic [DATA_W-1:0]   md_acc_q,       md_acc_d;
  logic [DATA_W-1:0]   md_opa_q,       md_opa_d;
  logic [DATA_W-1:0]   md_opb_q,       md_opb_d;
  logic [c_CNT_W-1:0]  md_cnt_q,       md_cnt_d;
  logic                md_div_q,       md_div_d;
  logic                md_link_q,      md_link_d;

  logic                w_fire;
  logic                w_is_md;
  logic [DATA_W-1:0]   w_diff;
  logic                w_zero;
  logic [DATA_W-1:0]   w_br_tgt;
  logic [DATA_W-1:0]   w_j_tgt;
  logic [DATA_W-1:0]   w_pc_next;
  logic [DATA_W-1:0]   w_alu;
  logic [DATA_W-1:0]   w_result;
  logic [DATA_W-1:0]   w_mul_acc;
  logic [DATA_W:0]     w_rem_sh;
  logic [DATA_W:0]     w_rem_sub;
  logic                w_div_ok;
  logic [DATA_W-1:0]   w_md_res;
  logic                w_md_last;

  assign in_ready_o     = (state_q == S_IDLE) && (!out_valid_q || out_ready_i);
  assign w_fire         = in_valid_i && in_ready_o;
  assign w_is_md        = (op_sel_i == c_OP_MUL) || (op_sel_i == c_OP_DIVU);

  assign out_valid_o    = out_valid_q;
  assign out_result_o   = out_result_q;
  assign out_pc_next_o  = out_pc_next_q;
  assign out_redirect_o = out_redirect_q;
  assign busy_o         = (state_q == S_BUSY);
  assign exl_o          = status_q[0];

  assign w_diff   = src_a_i - src_b_i;
  assign w_zero   = (w_diff == '0);
  assign w_br_tgt = pc_4_i + (imm_ext_i << 2);
  assign w_j_tgt  = {pc_4_i[DATA_W-1:28], instr_index_i, 2'b00};

  always_comb begin
    w_pc_next = pc_4_i;
    if (branch_i && w_zero)          w_pc_next = w_br_tgt;
    else if (jr_i)                   w_pc_next = src_a_i;
    else if (j_i)                    w_pc_next = w_j_tgt;
    else if (op_sel_i == c_OP_ERET)  w_pc_next = epc_q;
    else if (op_sel_i == c_OP_SYSCALL) w_pc_next = c_EXC_VEC;
  end

  // Shifts operate on src_b (the rt operand), matching MIPS sll/srl.
  always_comb begin
    w_alu = '0;
    case (op_sel_i)
      c_OP_SUB:  w_alu = w_diff;
      c_OP_AND:  w_alu = src_a_i & src_b_i;
      c_OP_OR:   w_alu = src_a_i | src_b_i;
      c_OP_XOR:  w_alu = src_a_i ^ src_b_i;
      c_OP_SLT:  w_alu[0] = ($signed(src_a_i) < $signed(src_b_i));
      c_OP_SLL:  w_alu = src_b_i << shamt_i;
      c_OP_SRL:  w_alu = src_b_i >> shamt_i;
      c_OP_MFC0: begin
        case (cp0_sel_i)
          2'd0:    w_alu = epc_q;
          2'd1:    w_alu = cause_q;
          2'd2:    w_alu = status_q;
          default: w_alu = '0;
        endcase
      end
      c_OP_MUL, c_OP_DIVU, c_OP_SYSCALL, c_OP_ERET, c_OP_MTC0: w_alu = '0;
      default:   w_alu = src_a_i + src_b_i;
    endcase
  end

  assign w_result = link_i ? pc_4_i : w_alu;

  // MUL: opa is the shifting multiplicand, opb the shifting multiplier.
  // DIVU: acc is the partial remainder, opa shifts dividend out / quotient in.
  assign w_mul_acc = md_acc_q + (md_opb_q[0] ? md_opa_q : '0);
  assign w_rem_sh  = {md_acc_q, md_opa_q[DATA_W-1]};
  assign w_rem_sub = w_rem_sh - {1'b0, md_opb_q};
  assign w_div_ok  = !w_rem_sub[DATA_W];
  assign w_md_res  = md_div_q ? {md_opa_q[DATA_W-2:0], w_div_ok} : w_mul_acc;
  assign w_md_last = (state_q == S_BUSY) && (md_cnt_q == c_CNT_W'(1));

  always_comb begin
    state_d        = state_q;
    out_valid_d    = out_valid_q && !out_ready_i;
    out_result_d   = out_result_q;
    out_pc_next_d  = out_pc_next_q;
    out_redirect_d = out_redirect_q;
    epc_d          = epc_q;
    cause_d        = cause_q;
    status_d       = status_q;
    md_acc_d       = md_acc_q;
    md_opa_d       = md_opa_q;
    md_opb_d       = md_opb_q;
    md_cnt_d       = md_cnt_q;
    md_div_d       = md_div_q;
    md_link_d      = md_link_q;

    if (w_fire) begin
      out_pc_next_d  = w_pc_next;
      out_redirect_d = (w_pc_next != pc_4_i);
      out_result_d   = w_result;
      if (w_is_md) begin
        state_d   = S_BUSY;
        md_cnt_d  = c_CNT_W'(MD_ITER);
        md_acc_d  = '0;
        md_opa_d  = src_a_i;
        md_opb_d  = src_b_i;
        md_div_d  = (op_sel_i == c_OP_DIVU);
        md_link_d = link_i;
      end else begin
        out_valid_d = 1'b1;
      end

      case (op_sel_i)
        c_OP_SYSCALL: begin
          cause_d[6:2] = c_EXC_SYS;
          // A nested syscall must not clobber the original return address.
          if (!status_q[0]) begin
            epc_d       = pc_4_i;
            status_d[0] = 1'b1;
          end
        end
        c_OP_ERET: status_d[0] = 1'b0;
        c_OP_MTC0: begin
          if (cp0_sel_i == 2'd0) epc_d    = src_b_i;
          if (cp0_sel_i == 2'd2) status_d = src_b_i;
        end
        default: ;
      endcase
    end

    if (state_q == S_BUSY) begin
      md_cnt_d = md_cnt_q - c_CNT_W'(1);
      if (md_div_q) begin
        md_acc_d = w_div_ok ? w_rem_sub[DATA_W-1:0] : w_rem_sh[DATA_W-1:0];
        md_opa_d = {md_opa_q[DATA_W-2:0], w_div_ok};
      end else begin
        md_acc_d = w_mul_acc;
        md_opa_d = md_opa_q << 1;
        md_opb_d = md_opb_q >> 1;
      end
      if (w_md_last) begin
        state_d     = S_IDLE;
        out_valid_d = 1'b1;
        if (!md_link_q) out_result_d = w_md_res;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q        <= S_IDLE;
      out_valid_q    <= 1'b0;
      out_result_q   <= '0;
      out_pc_next_q  <= '0;
      out_redirect_q <= 1'b0;
      epc_q          <= '0;
      cause_q        <= '0;
      status_q       <= '0;
      md_acc_q       <= '0;
      md_opa_q       <= '0;
      md_opb_q       <= '0;
      md_cnt_q       <= '0;
      md_div_q       <= 1'b0;
      md_link_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      out_valid_q    <= out_valid_d;
      out_result_q   <= out_result_d;
      out_pc_next_q  <= out_pc_next_d;
      out_redirect_q <= out_redirect_d;
      epc_q          <= epc_d;
      cause_q        <= cause_d;
      status_q       <= status_d;
      md_acc_q       <= md_acc_d;
      md_opa_q       <= md_opa_d;
      md_opb_q       <= md_opb_d;
      md_cnt_q       <= md_cnt_d;
      md_div_q       <= md_div_d;
      md_link_q      <= md_link_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_execute_stage_pipe.sv
`default_nettype none
// Testbench for execute_stage_pipe: vector table plus scoreboard of expected results.
module tb_execute_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [3:0]  op_sel;
  logic [31:0] src_a, src_b, pc_4, imm_ext;
  logic [4:0]  shamt;
  logic [25:0] instr_index;
  logic        branch, jr, j, link;
  logic [1:0]  cp0_sel;
  logic        out_valid, out_ready;
  logic [31:0] out_result, out_pc_next;
  logic        out_redirect, busy, exl;

  always #5 clk = ~clk;

  execute_stage_pipe dut (
    .clock_i(clk), .reset_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .op_sel_i(op_sel), .src_a_i(src_a), .src_b_i(src_b), .pc_4_i(pc_4),
    .imm_ext_i(imm_ext), .shamt_i(shamt), .instr_index_i(instr_index),
    .branch_i(branch), .jr_i(jr), .j_i(j), .link_i(link), .cp0_sel_i(cp0_sel),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_result_o(out_result),
    .out_pc_next_o(out_pc_next), .out_redirect_o(out_redirect),
    .busy_o(busy), .exl_o(exl)
  );

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a, b, pc4, imm;
    logic [4:0]  sh;
    logic [25:0] idx;
    logic        br, jr, j, link;
    logic [1:0]  sel;
    logic [31:0] exp_res, exp_pc;
    bit          chk_res;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] res, pc;
    logic        redir;
    bit          chk_res;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [3:0] op,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] pc4, input logic [31:0] exp_res,
                              input logic [31:0] exp_pc, input logic [31:0] imm = 0,
                              input logic [4:0] sh = 0, input logic [25:0] idx = 0,
                              input logic br = 0, input logic jrf = 0,
                              input logic jf = 0, input logic lk = 0,
                              input logic [1:0] sel = 0, input bit chk = 1);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b; v.pc4 = pc4; v.imm = imm;
    v.sh = sh; v.idx = idx; v.br = br; v.jr = jrf; v.j = jf; v.link = lk;
    v.sel = sel; v.exp_res = exp_res; v.exp_pc = exp_pc; v.chk_res = chk;
    return v;
  endfunction

  task automatic set_inputs(input vec_t v);
    op_sel = v.op; src_a = v.a; src_b = v.b; pc_4 = v.pc4; imm_ext = v.imm;
    shamt = v.sh; instr_index = v.idx; branch = v.br; jr = v.jr; j = v.j;
    link = v.link; cp0_sel = v.sel;
  endtask

  task automatic push_exp(input vec_t v);
    exp_t x;
    x.name = v.name; x.res = v.exp_res; x.pc = v.exp_pc;
    x.redir = (v.exp_pc != v.pc4); x.chk_res = v.chk_res;
    sb.push_back(x);
  endtask

  // Entered and left at posedge+1; the transfer edge is the posedge inside.
  task automatic issue(input vec_t v);
    int n = 0;
    set_inputs(v);
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL %s_issue_timeout: in_ready=0 for %0d cycles, required 1", v.name, n);
    end else begin
      push_exp(v);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_result: got result %h with nothing pending", out_result);
      end else begin
        e = sb.pop_front();
        if (e.chk_res) check({e.name, "_result"}, out_result, e.res);
        check({e.name, "_pc_next"}, out_pc_next, e.pc);
        check({e.name, "_redirect"}, {31'b0, out_redirect}, {31'b0, e.redir});
      end
    end
  end

  initial begin
    vec_t tbl[$];
    vec_t v;
    int   bad;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    set_inputs(mk("idle", 0, 0, 0, 0, 0, 0));
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_redirect", {31'b0, out_redirect}, 32'd0);
    check("rst_result", out_result, 32'd0);
    check("rst_pc_next", out_pc_next, 32'd0);
    check("rst_exl", {31'b0, exl}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;

    tbl.push_back(mk("add_wrap", 0, 32'hFFFF_FFFF, 1, 32'h1004, 0, 32'h1004));
    tbl.push_back(mk("sub_neg", 1, 5, 7, 32'h1008, 32'hFFFF_FFFE, 32'h1008));
    tbl.push_back(mk("and", 2, 32'hF0F0, 32'hFF00, 32'h100C, 32'hF000, 32'h100C));
    tbl.push_back(mk("or", 3, 32'hF0F0, 32'hFF00, 32'h1010, 32'hFFF0, 32'h1010));
    tbl.push_back(mk("xor", 4, 32'hF0F0, 32'hFF00, 32'h1014, 32'h0FF0, 32'h1014));
    tbl.push_back(mk("slt_true", 5, 32'hFFFF_FFFF, 1, 32'h1018, 1, 32'h1018));
    tbl.push_back(mk("slt_false", 5, 1, 32'hFFFF_FFFF, 32'h101C, 0, 32'h101C));
    tbl.push_back(mk("sll4", 6, 32'h8000_0001, 32'h8000_0001, 32'h1020, 32'h10, 32'h1020, 0, 5'd4));
    tbl.push_back(mk("srl31", 7, 32'h8000_0001, 32'h8000_0001, 32'h1024, 1, 32'h1024, 0, 5'd31));
    tbl.push_back(mk("op14_add", 14, 3, 4, 32'h1028, 7, 32'h1028));
    tbl.push_back(mk("beq_taken", 0, 5, 5, 32'h100, 10, 32'hF8, 32'hFFFF_FFFE, 0, 0, 1));
    tbl.push_back(mk("beq_not", 0, 5, 6, 32'h100, 11, 32'h100, 32'hFFFF_FFFE, 0, 0, 1));
    tbl.push_back(mk("jr", 0, 32'h2000, 0, 32'h104, 32'h2000, 32'h2000, 0, 0, 0, 0, 1));
    tbl.push_back(mk("j", 0, 0, 0, 32'h1000_0004, 0, 32'h1048_D158, 0, 0, 26'h0123456, 0, 0, 1));
    tbl.push_back(mk("jal_link", 0, 1, 2, 32'h1000_0004, 32'h1000_0004, 32'h1048_D158, 0, 0, 26'h0123456, 0, 0, 1, 1));
    tbl.push_back(mk("br_over_jr", 0, 5, 5, 32'h100, 10, 32'hF8, 32'hFFFF_FFFE, 0, 0, 1, 1));
    foreach (tbl[i]) issue(tbl[i]);

    // Iterative divide: exact busy window and result latency.
    issue(mk("divu_100_7", 9, 100, 7, 32'h200, 14, 32'h200));
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (!busy || in_ready || out_valid) bad++;
    end
    check("divu_busy_window_bad_cycles", 32'(bad), 32'd0);
    @(negedge clk);
    check("divu_valid_busy_at_N+33", {30'b0, out_valid, busy}, 32'd2);
    @(posedge clk); #1;
    issue(mk("divu_by_zero", 9, 5, 0, 32'h204, 32'hFFFF_FFFF, 32'h204));
    issue(mk("mul_basic", 8, 32'h12345, 32'h1000, 32'h208, 32'h1234_5000, 32'h208));
    issue(mk("mul_wrap", 8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h20C, 1, 32'h20C));
    issue(mk("mul_link", 8, 3, 4, 32'h210, 32'h210, 32'h210, 0, 0, 0, 0, 0, 0, 1));

    // Exceptions and CP0.
    issue(mk("syscall1", 10, 0, 0, 32'h0040_0010, 0, 32'h0040_00EC, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    check("syscall1_exl", {31'b0, exl}, 32'd1);
    issue(mk("mfc0_epc1", 12, 0, 0, 32'h300, 32'h0040_0010, 32'h300));
    issue(mk("syscall2", 10, 0, 0, 32'h0050_0020, 0, 32'h0040_00EC, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    issue(mk("mfc0_epc2", 12, 0, 0, 32'h304, 32'h0040_0010, 32'h304));
    issue(mk("mfc0_cause", 12, 0, 0, 32'h308, 32'h20, 32'h308, 0, 0, 0, 0, 0, 0, 0, 2'd1));
    issue(mk("eret", 11, 0, 0, 32'h600, 0, 32'h0040_0010, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    check("eret_exl", {31'b0, exl}, 32'd0);

    // Output stall: result held, MTC0 presented but not applied until accepted.
    repeat (3) @(posedge clk); #1;
    out_ready = 1'b0;
    issue(mk("sub_stall", 1, 10, 3, 32'h44, 7, 32'h44));
    v = mk("mtc0_status", 13, 0, 1, 32'h48, 0, 32'h48, 0, 0, 0, 0, 0, 0, 0, 2'd2, 0);
    set_inputs(v);
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stall_valid", {31'b0, out_valid}, 32'd1);
      check("stall_result", out_result, 32'd7);
      check("stall_pc_next", out_pc_next, 32'h44);
      check("stall_in_ready", {31'b0, in_ready}, 32'd0);
      check("stall_exl", {31'b0, exl}, 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("mtc0_in_ready", {31'b0, in_ready}, 32'd1);
    if (in_ready) push_exp(v);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("mtc0_applied_exl", {31'b0, exl}, 32'd1);

    issue(mk("mtc0_epc", 13, 0, 32'hABCD, 32'h4C, 0, 32'h4C, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0));
    issue(mk("mfc0_epc3", 12, 0, 0, 32'h50, 32'hABCD, 32'h50));
    issue(mk("mtc0_cause", 13, 0, 32'hFFFF_FFFF, 32'h54, 0, 32'h54, 0, 0, 0, 0, 0, 0, 0, 2'd1, 0));
    issue(mk("mfc0_cause_ro", 12, 0, 0, 32'h58, 32'h20, 32'h58, 0, 0, 0, 0, 0, 0, 0, 2'd1));
    issue(mk("mfc0_sel3", 12, 0, 0, 32'h5C, 0, 32'h5C, 0, 0, 0, 0, 0, 0, 0, 2'd3));

    // Reset in the middle of a multiply aborts it with no late result.
    issue(mk("mul_abort", 8, 3, 5, 32'h60, 15, 32'h60));
    repeat (9) @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_valid", {31'b0, out_valid}, 32'd0);
    check("abort_exl", {31'b0, exl}, 32'd0);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    check("abort_no_late_result", 32'(bad), 32'd0);
    @(posedge clk); #1;
    issue(mk("mfc0_epc_after_rst", 12, 0, 0, 32'h64, 0, 32'h64));

    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/execute_stage_pipe.md
EXECUTE_STAGE_PIPE -- requirements
Module: execute_stage_pipe

Interface
REQ-001 Parameter: DATA_W, 32, datapath width; legal values 32 and 64.
REQ-002 Parameter: EXC_VECTOR, 32'h0040_00EC, syscall handler entry, zero-extended to DATA_W.
REQ-003 Parameter: MD_ITER, DATA_W, mul/div iteration count (one result bit per cycle).
REQ-004 Port: clock  in  1  sole clock, rising edge.
REQ-005 Port: reset  in  1  synchronous, active-high.
REQ-006 Port: in_valid / in_ready  in / out  1 / 1  issue handshake; transfer when both high.
REQ-007 Port: op_sel  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLL, 7 SRL, 8 MUL, 9 DIVU, 10 SYSCALL, 11 ERET, 12 MFC0, 13 MTC0; 14-15 behave as ADD.
REQ-008 Port: src_a, src_b, pc_4, imm_ext  in  DATA_W each  operands, PC+4, sign-extended immediate.
REQ-009 Port: shamt  in  5 (6 when DATA_W=64)  shift amount; instr_index  in  26  jump target field.
REQ-010 Port: branch, jr, j, link  in  1 each  control-flow flags; cp0_sel  in  2  0 EPC, 1 Cause, 2 Status, 3 reads zero/ignores writes.
REQ-011 Port: out_valid / out_ready  out / in  1 / 1  result handshake.
REQ-012 Port: out_result, out_pc_next  out  DATA_W  result and resolved next PC; out_redirect  out  1  high when out_pc_next != captured pc_4.
REQ-013 Port: busy  out  1  mul/div in progress; exl  out  1  Status[0].

Function
REQ-014 in_ready SHALL equal !busy && (!out_valid || out_ready).
REQ-015 Single-cycle ops accepted in cycle N SHALL present out_valid in cycle N+1.
REQ-016 MUL/DIVU accepted in cycle N SHALL raise busy from N+1 through N+MD_ITER, out_valid in N+MD_ITER+1.
REQ-017 Output registers SHALL hold all values unchanged while out_valid && !out_ready.
REQ-018 ALU results SHALL be DATA_W bits, wrap modulo 2^DATA_W; SLT signed, result 1 or 0; SLL/SRL by shamt, zero fill.
REQ-019 MUL SHALL return low DATA_W bits of unsigned product via shift-add.
REQ-020 DIVU SHALL return unsigned quotient via restoring division; divisor 0 SHALL yield all-ones, no exception.
REQ-021 link=1 SHALL force out_result=pc_4 regardless of op_sel.
REQ-022 zero SHALL be (src_a - src_b)==0; branch target pc_4+(imm_ext<<2); jump target {pc_4[DATA_W-1:28], instr_index, 2'b00}.
REQ-023 out_pc_next priority: branch&zero -> branch target; jr -> src_a; j -> jump target; ERET -> EPC; SYSCALL -> EXC_VECTOR; else pc_4.
REQ-024 SYSCALL with exl=0 SHALL set EPC=pc_4, Cause[6:2]=5'd8, exl=1 at acceptance edge; with exl=1 SHALL leave EPC unchanged but still vector.
REQ-025 ERET SHALL read EPC pre-update and clear exl at acceptance edge.
REQ-026 MTC0 SHALL write src_b to cp0_sel register at acceptance edge; MFC0 SHALL return it as out_result; Cause is read-only except ExcCode via SYSCALL.
REQ-027 CP0 state SHALL update only on accepted transfers, never while stalled.

Reset
REQ-028 reset SHALL clear out_valid, busy, out_redirect, out_result, out_pc_next, EPC, Cause, Status in the next edge.
REQ-029 reset during mul/div SHALL abort the operation; no result SHALL be emitted.
REQ-030 in_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-031 ADD 0xFFFF_FFFF+1, out_ready=1 -> cycle N+1: out_result=0, out_pc_next=pc_4, out_redirect=0.
REQ-032 DIVU 100/7 then DIVU 5/0 -> 14 after 33 cycles, then 0xFFFF_FFFF; in_ready=0 throughout busy.
REQ-033 SYSCALL pc_4=0x0040_0010 -> out_pc_next=0x0040_00EC, redirect=1, EPC=0x0040_0010, exl=1; second SYSCALL keeps EPC; ERET -> pc_next=0x0040_0010, exl=0.
REQ-034 branch=1, src_a=src_b=5, imm_ext=0xFFFF_FFFE, pc_4=0x100 -> out_pc_next=0xF8; same with src_b=6 -> 0x100.
REQ-035 out_ready=0 for 3 cycles after SUB result -> output stable, in_ready=0, MTC0 presented meanwhile not applied until accepted.
REQ-036 reset asserted mid-MUL cycle 10 -> next cycle busy=0, out_valid=0, no late result.
